// File: rtl/instr_sequencer.sv
// ---------------------------------------------------------------------------
// instr_sequencer
//
// Multi-cycle fetch/decode/execute controller for the 9-bit-instruction core.
// Owns the PC and the instruction register, drives the instruction-memory
// fetch handshake and the data-memory request handshake, and issues the
// register-file write strobe. Branch and jump targets come from a small
// target lookup table indexed by the 4-bit immediate ir[3:0].
//
// Ports:
//   clk_i, reset_i         clock, synchronous active-high reset
//   start_i                begin execution at PC 0 (only from IDLE or HALT)
//   imem_req_o/addr_o      fetch request and address (= pc)
//   imem_valid_i/data_i    fetch data return
//   ir_o                   current instruction, feeds the decoder
//   zero_flag_i            ALU zero flag for conditional branches
//   reg_we_o               register-file write strobe (1-cycle pulse)
//   mem_req_o, mem_we_o    data-memory request and store qualifier
//   mem_ack_i              data-memory completion
//   lut_we_i/waddr_i/wdata_i  target-LUT write port
//   pc_o, busy_o, done_o   status
//   retired_o              retired-instruction count
//   stall_cycles_o         handshake-wait cycle count
//
// Configuration macro: INSTR_SEQ_PERF_CNT_EN
//   defined   -> retired_o / stall_cycles_o are saturating 16-bit counters
//   undefined -> both outputs tied to 0, no counter flops
// ---------------------------------------------------------------------------
module instr_sequencer #(
    parameter int PC_W      = 10,
    parameter int LUT_DEPTH = 16
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            start_i,
    output logic            imem_req_o,
    output logic [PC_W-1:0] imem_addr_o,
    input  logic            imem_valid_i,
    input  logic [8:0]      imem_data_i,
    output logic [8:0]      ir_o,
    input  logic            zero_flag_i,
    output logic            reg_we_o,
    output logic            mem_req_o,
    output logic            mem_we_o,
    input  logic            mem_ack_i,
    input  logic            lut_we_i,
    input  logic [3:0]      lut_waddr_i,
    input  logic [PC_W-1:0] lut_wdata_i,
    output logic [PC_W-1:0] pc_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [15:0]     retired_o,
    output logic [15:0]     stall_cycles_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM_WAIT,
        S_HALT
    } state_t;

    typedef enum logic [2:0] {
        C_ALU,
        C_BRANCH,
        C_JUMP,
        C_LOAD,
        C_STORE,
        C_HALT,
        C_NOP
    } iclass_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [8:0]      ir_q, ir_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [PC_W-1:0] lut_q [LUT_DEPTH];

    iclass_t         iclass;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] lut_target;
    logic            retire;
    logic            stall;
    logic            start_accept;

    // HALT (9'h1FF) must be recognised before the generic 11xxxxxxx NOP class.
    always_comb begin
        iclass = C_ALU;
        if (ir_q == 9'h1FF)
            iclass = C_HALT;
        else if (ir_q[8:5] == 4'b0111)
            iclass = C_BRANCH;
        else if (ir_q[8:4] == 5'b10000)
            iclass = C_JUMP;
        else if (ir_q[8:4] == 5'b10001)
            iclass = C_LOAD;
        else if (ir_q[8:5] == 4'b1001)
            iclass = C_STORE;
        else if (ir_q[8:7] == 2'b11)
            iclass = C_NOP;
    end

    assign pc_inc     = pc_q + PC_W'(1);
    // Reads the registered table, so a same-cycle write is not yet visible.
    assign lut_target = lut_q[ir_q[3:0]];

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        imem_req_o   = 1'b0;
        reg_we_o     = 1'b0;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        retire       = 1'b0;
        stall        = 1'b0;
        start_accept = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    start_accept = 1'b1;
                    pc_d         = '0;
                    state_d      = S_FETCH;
                end
            end
            S_FETCH: begin
                imem_req_o = 1'b1;
                if (imem_valid_i) begin
                    ir_d    = imem_data_i;
                    state_d = S_DECODE;
                end else begin
                    stall = 1'b1;
                end
            end
            S_DECODE: begin
                case (iclass)
                    C_LOAD, C_STORE: state_d = S_MEM_WAIT;
                    C_HALT: begin
                        retire  = 1'b1;
                        state_d = S_HALT;
                    end
                    default: state_d = S_EXEC;
                endcase
            end
            S_EXEC: begin
                retire  = 1'b1;
                state_d = S_FETCH;
                case (iclass)
                    C_ALU: begin
                        reg_we_o = 1'b1;
                        pc_d     = pc_inc;
                    end
                    C_JUMP: pc_d = lut_target;
                    // ir[4]=0 branches on zero, ir[4]=1 branches on not-zero.
                    C_BRANCH: pc_d = (zero_flag_i == ~ir_q[4]) ? lut_target : pc_inc;
                    default: pc_d = pc_inc;
                endcase
            end
            S_MEM_WAIT: begin
                mem_req_o = 1'b1;
                mem_we_o  = (iclass == C_STORE);
                if (mem_ack_i) begin
                    reg_we_o = (iclass == C_LOAD);
                    retire   = 1'b1;
                    pc_d     = pc_inc;
                    state_d  = S_FETCH;
                end else begin
                    stall = 1'b1;
                end
            end
            S_HALT: begin
                if (start_i) begin
                    start_accept = 1'b1;
                    pc_d         = '0;
                    state_d      = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Status flags are registered from the next state so they always match
    // the state the FSM is actually in.
    always_comb begin
        busy_d = (state_d == S_FETCH) || (state_d == S_DECODE) ||
                 (state_d == S_EXEC)  || (state_d == S_MEM_WAIT);
        done_d = (state_d == S_HALT);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < LUT_DEPTH; i++)
                lut_q[i] <= '0;
        end else if (lut_we_i) begin
            lut_q[lut_waddr_i] <= lut_wdata_i;
        end
    end

    assign imem_addr_o = pc_q;
    assign ir_o        = ir_q;
    assign pc_o        = pc_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

`ifdef INSTR_SEQ_PERF_CNT_EN
    logic [15:0] retired_q;
    logic [15:0] stall_q;

    // Both counters saturate rather than wrap.
    always_ff @(posedge clk_i) begin
        if (reset_i || start_accept) begin
            retired_q <= '0;
            stall_q   <= '0;
        end else begin
            if (retire && (retired_q != 16'hFFFF))
                retired_q <= retired_q + 16'd1;
            if (stall && (stall_q != 16'hFFFF))
                stall_q <= stall_q + 16'd1;
        end
    end

    assign retired_o      = retired_q;
    assign stall_cycles_o = stall_q;
`else
    logic unused_perf;
    assign unused_perf    = retire ^ stall ^ start_accept;
    assign retired_o      = '0;
    assign stall_cycles_o = '0;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// ---------------------------------------------------------------------------
// tb_instr_sequencer
//
// Directed self-checking bench for instr_sequencer (PC_W=10). Expected values
// are hand-computed constants. Counter expectations collapse to 0 when
// INSTR_SEQ_PERF_CNT_EN is not defined.
// ---------------------------------------------------------------------------
module tb_instr_sequencer;

    localparam int PC_W = 10;
`ifdef INSTR_SEQ_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic            clk;
    logic            reset;
    logic            start;
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_valid;
    logic [8:0]      imem_data;
    logic [8:0]      ir;
    logic            zero_flag;
    logic            reg_we;
    logic            mem_req;
    logic            mem_we;
    logic            mem_ack;
    logic            lut_we;
    logic [3:0]      lut_waddr;
    logic [PC_W-1:0] lut_wdata;
    logic [PC_W-1:0] pc;
    logic            busy;
    logic            done;
    logic [15:0]     retired;
    logic [15:0]     stall_cycles;

    int compared;
    int mismatched;

    instr_sequencer #(.PC_W(PC_W), .LUT_DEPTH(16)) dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .start_i        (start),
        .imem_req_o     (imem_req),
        .imem_addr_o    (imem_addr),
        .imem_valid_i   (imem_valid),
        .imem_data_i    (imem_data),
        .ir_o           (ir),
        .zero_flag_i    (zero_flag),
        .reg_we_o       (reg_we),
        .mem_req_o      (mem_req),
        .mem_we_o       (mem_we),
        .mem_ack_i      (mem_ack),
        .lut_we_i       (lut_we),
        .lut_waddr_i    (lut_waddr),
        .lut_wdata_i    (lut_wdata),
        .pc_o           (pc),
        .busy_o         (busy),
        .done_o         (done),
        .retired_o      (retired),
        .stall_cycles_o (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] expCnt(input int n);
        return PERF ? 16'(n) : 16'd0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic st, input logic iv, input logic [8:0] id,
                                 input logic zf, input logic ack);
        start      = st;
        imem_valid = iv;
        imem_data  = id;
        zero_flag  = zf;
        mem_ack    = ack;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic lutWrite(input logic [3:0] a, input logic [PC_W-1:0] d);
        lut_we    = 1'b1;
        lut_waddr = a;
        lut_wdata = d;
        tick();
        lut_we    = 1'b0;
    endtask

    // Called in a FETCH cycle: returns the instruction immediately, then
    // spends the DECODE cycle, leaving the FSM in the following state.
    task automatic fetchDecode(input logic [8:0] instr);
        applyStimulus(1'b0, 1'b1, instr, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 9'h000, 1'b0, 1'b0);
        tick();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b1;
        lut_we     = 1'b0;
        lut_waddr  = '0;
        lut_wdata  = '0;
        applyStimulus(1'b0, 1'b0, 9'h000, 1'b0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        checkOutput("rst_pc", 16'(pc), 16'h000);
        checkOutput("rst_ir", 16'(ir), 16'h000);
        checkOutput("rst_busy", 16'(busy), 16'h0);
        checkOutput("rst_done", 16'(done), 16'h0);
        checkOutput("rst_imem_req", 16'(imem_req), 16'h0);
        checkOutput("rst_mem_req", 16'(mem_req), 16'h0);
        checkOutput("rst_reg_we", 16'(reg_we), 16'h0);
        checkOutput("rst_retired", retired, 16'h0);
        checkOutput("rst_stall", stall_cycles, 16'h0);

        lutWrite(4'd3, 10'h2A0);
        lutWrite(4'd5, 10'h3FF);

        // ALU 0x005 with valid on the second request cycle
        applyStimulus(1'b1, 1'b0, 9'h000, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 9'h000, 1'b0, 1'b0);
        #1;
        checkOutput("f1_imem_req", 16'(imem_req), 16'h1);
        checkOutput("f1_imem_addr", 16'(imem_addr), 16'h000);
        checkOutput("f1_busy", 16'(busy), 16'h1);
        tick();
        applyStimulus(1'b0, 1'b1, 9'h005, 1'b0, 1'b0);
        #1;
        checkOutput("f2_imem_req", 16'(imem_req), 16'h1);
        tick();
        applyStimulus(1'b0, 1'b0, 9'h000, 1'b0, 1'b0);
        #1;
        checkOutput("alu_ir", 16'(ir), 16'h005);
        checkOutput("alu_dec_reg_we", 16'(reg_we), 16'h0);
        checkOutput("alu_dec_imem_req", 16'(imem_req), 16'h0);
        tick();
        checkOutput("alu_exec_reg_we", 16'(reg_we), 16'h1);
        checkOutput("alu_exec_pc", 16'(pc), 16'h000);
        tick();
        checkOutput("alu_pc", 16'(pc), 16'h001);
        checkOutput("alu_after_reg_we", 16'(reg_we), 16'h0);
        checkOutput("alu_stall", stall_cycles, expCnt(1));
        checkOutput("alu_retired", retired, expCnt(1));

        // Branch-if-zero taken; start while busy must be ignored
        fetchDecode(9'h0E3);
        applyStimulus(1'b1, 1'b0, 9'h000, 1'b1, 1'b0);
        #1;
        checkOutput("bz_reg_we", 16'(reg_we), 16'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 9'h000, 1'b0, 1'b0);
        checkOutput("bz_taken_pc", 16'(pc), 16'h2A0);

        fetchDecode(9'h0E3);
        tick();
        checkOutput("bz_not_taken_pc", 16'(pc), 16'h2A1);

        fetchDecode(9'h0F3);
        applyStimulus(1'b0, 1'b0, 9'h000, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 9'h000, 1'b0, 1'b0);
        checkOutput("bnz_not_taken_pc", 16'(pc), 16'h2A2);

        fetchDecode(9'h0F3);
        tick();
        checkOutput("bnz_taken_pc", 16'(pc), 16'h2A0);

        // LOAD with ack on the fourth MEM_WAIT cycle
        fetchDecode(9'h118);
        for (int i = 0; i < 3; i++) begin
            checkOutput("ld_wait_mem_req", 16'(mem_req), 16'h1);
            checkOutput("ld_wait_mem_we", 16'(mem_we), 16'h0);
            checkOutput("ld_wait_reg_we", 16'(reg_we), 16'h0);
            tick();
        end
        applyStimulus(1'b0, 1'b0, 9'h000, 1'b0, 1'b1);
        #1;
        checkOutput("ld_ack_mem_req", 16'(mem_req), 16'h1);
        checkOutput("ld_ack_mem_we", 16'(mem_we), 16'h0);
        checkOutput("ld_ack_reg_we", 16'(reg_we), 16'h1);
        tick();
        applyStimulus(1'b0, 1'b0, 9'h000, 1'b0, 1'b0);
        #1;
        checkOutput("ld_pc", 16'(pc), 16'h2A1);
        checkOutput("ld_after_mem_req", 16'(mem_req), 16'h0);

        // STORE with same-cycle ack
        fetchDecode(9'h120);
        applyStimulus(1'b0, 1'b0, 9'h000, 1'b0, 1'b1);
        #1;
        checkOutput("st_mem_req", 16'(mem_req), 16'h1);
        checkOutput("st_mem_we", 16'(mem_we), 16'h1);
        checkOutput("st_reg_we", 16'(reg_we), 16'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 9'h000, 1'b0, 1'b0);
        #1;
        checkOutput("st_after_mem_we", 16'(mem_we), 16'h0);
        checkOutput("st_pc", 16'(pc), 16'h2A2);
        checkOutput("st_stall", stall_cycles, expCnt(4));
        checkOutput("st_retired", retired, expCnt(7));

        // JUMP to 0x3FF, then ALU wraps the PC; imem_valid in EXEC is ignored
        fetchDecode(9'h105);
        tick();
        checkOutput("jmp_pc", 16'(pc), 16'h3FF);
        checkOutput("jmp_imem_addr", 16'(imem_addr), 16'h3FF);
        fetchDecode(9'h005);
        applyStimulus(1'b0, 1'b1, 9'h1FF, 1'b0, 1'b0);
        #1;
        checkOutput("wrap_reg_we", 16'(reg_we), 16'h1);
        tick();
        applyStimulus(1'b0, 1'b0, 9'h000, 1'b0, 1'b0);
        checkOutput("wrap_pc", 16'(pc), 16'h000);
        checkOutput("wrap_ir", 16'(ir), 16'h005);

        // NOP
        fetchDecode(9'h180);
        checkOutput("nop_reg_we", 16'(reg_we), 16'h0);
        tick();
        checkOutput("nop_pc", 16'(pc), 16'h001);

        // HALT at pc 1, then restart
        fetchDecode(9'h1FF);
        checkOutput("halt_done", 16'(done), 16'h1);
        checkOutput("halt_busy", 16'(busy), 16'h0);
        checkOutput("halt_pc", 16'(pc), 16'h001);
        checkOutput("halt_imem_req", 16'(imem_req), 16'h0);
        checkOutput("halt_retired", retired, expCnt(11));
        checkOutput("halt_stall", stall_cycles, expCnt(4));
        tick();
        checkOutput("halt_hold_done", 16'(done), 16'h1);
        checkOutput("halt_hold_pc", 16'(pc), 16'h001);
        applyStimulus(1'b1, 1'b0, 9'h000, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 9'h000, 1'b0, 1'b0);
        #1;
        checkOutput("restart_pc", 16'(pc), 16'h000);
        checkOutput("restart_done", 16'(done), 16'h0);
        checkOutput("restart_busy", 16'(busy), 16'h1);
        checkOutput("restart_imem_req", 16'(imem_req), 16'h1);
        checkOutput("restart_retired", retired, 16'h0);
        checkOutput("restart_stall", stall_cycles, 16'h0);

        // ALU then LOAD, reset asserted during MEM_WAIT
        fetchDecode(9'h005);
        tick();
        checkOutput("pre_rst_pc", 16'(pc), 16'h001);
        fetchDecode(9'h118);
        checkOutput("pre_rst_mem_req", 16'(mem_req), 16'h1);
        checkOutput("pre_rst_retired", retired, expCnt(1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        checkOutput("mrst_mem_req", 16'(mem_req), 16'h0);
        checkOutput("mrst_mem_we", 16'(mem_we), 16'h0);
        checkOutput("mrst_pc", 16'(pc), 16'h000);
        checkOutput("mrst_ir", 16'(ir), 16'h000);
        checkOutput("mrst_busy", 16'(busy), 16'h0);
        checkOutput("mrst_done", 16'(done), 16'h0);
        checkOutput("mrst_imem_req", 16'(imem_req), 16'h0);
        checkOutput("mrst_reg_we", 16'(reg_we), 16'h0);
        checkOutput("mrst_retired", retired, 16'h0);

        // LUT was cleared by reset; a same-cycle write is not seen by the jump
        applyStimulus(1'b1, 1'b0, 9'h000, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 9'h000, 1'b0, 1'b0);
        fetchDecode(9'h103);
        lut_we    = 1'b1;
        lut_waddr = 4'd3;
        lut_wdata = 10'h155;
        tick();
        lut_we = 1'b0;
        checkOutput("lut_old_read_pc", 16'(pc), 16'h000);
        fetchDecode(9'h103);
        tick();
        checkOutput("lut_new_read_pc", 16'(pc), 16'h155);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
